compress_decoder: RTL and testbench

//  Registered RV32C expander for the ID stage. Takes the fetched 32-bit word; if [1:0]!=2'b11 it expands the
//  16-bit RVC halfword to its RV32I equivalent, else it passes the word through. Output feeds the main decoder
//  and immediate-extension logic. Flags illegal/reserved RVC encodings.

---
 rtl/compress_decoder_pkg.sv | 41 ++++
 rtl/compress_decoder_if.sv | 20 ++
 rtl/compress_decoder_rvc_expand_comb.sv | 145 ++++++++++++++
 rtl/compress_decoder.sv | 64 ++++++
 tb/tb_compress_decoder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/compress_decoder_pkg.sv
// Shared constants and payload types for the RV32C expander.
package compress_decoder_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned HLEN  = 16;
    localparam int unsigned REG_W = 5;
    localparam int unsigned OPC_W = 7;

    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'h13;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'h33;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'h73;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ZERO = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] EBREAK_INSTR = {12'h001, 5'd0, 3'b000, 5'd0, OPC_SYSTEM};

    // Expansion result of one RVC halfword.
    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] instr;
    } rvc_exp_t;

endpackage

// File: rtl/compress_decoder_if.sv
// Instruction bus between fetch/ID and the compressed-instruction expander.
interface compress_decoder_if;

    logic                                   enable;
    logic [compress_decoder_pkg::XLEN-1:0]  instr_i;
    logic [compress_decoder_pkg::XLEN-1:0]  instr_o;
    logic                                   is_compressed_o;
    logic                                   illegal_instr_o;

    modport master (
        output enable, instr_i,
        input  instr_o, is_compressed_o, illegal_instr_o
    );

    modport slave (
        input  enable, instr_i,
        output instr_o, is_compressed_o, illegal_instr_o
    );

endinterface

// File: rtl/compress_decoder_rvc_expand_comb.sv
// Pure combinational RVC halfword -> RV32I expansion with illegal flag.
// Optional: RVC_HINT_ILLEGAL_EN makes RVC HINT encodings report illegal.
module rvc_expand_comb
    import compress_decoder_pkg::*;
(
    input  logic [HLEN-1:0] half_i,
    output rvc_exp_t        expanded_c
);

    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rdp;
    logic [REG_W-1:0] rs1p;
    logic             b12;
    logic [11:0]      imm6_sx;
    logic [XLEN-1:0]  instr;
    logic             illegal;

    assign rd      = half_i[11:7];
    assign rs2     = half_i[6:2];
    assign rdp     = {2'b01, half_i[4:2]};
    assign rs1p    = {2'b01, half_i[9:7]};
    assign b12     = half_i[12];
    assign imm6_sx = {{6{b12}}, b12, half_i[6:2]};

    // Decode quadrant/funct3 and rebuild the 32-bit encoding.
    always_comb begin
        instr   = NOP_INSTR;
        illegal = 1'b0;
        case (half_i[1:0])
            2'b00: begin
                case (half_i[15:13])
                    3'b000: begin
                        instr   = {2'b00, half_i[10:7], half_i[12:11], half_i[5], half_i[6], 2'b00,
                                   5'd2, F3_ADD, rdp, OPC_OP_IMM};
                        illegal = (half_i[12:5] == 8'h00);
                    end
                    3'b010: instr = {5'b0, half_i[5], half_i[12:10], half_i[6], 2'b00,
                                     rs1p, F3_W, rdp, OPC_LOAD};
                    3'b110: instr = {5'b0, half_i[5], half_i[12], rdp, rs1p, F3_W,
                                     half_i[11:10], half_i[6], 2'b00, OPC_STORE};
                    default: illegal = 1'b1;
                endcase
            end
            2'b01: begin
                case (half_i[15:13])
                    3'b000: instr = {imm6_sx, rd, F3_ADD, rd, OPC_OP_IMM};
                    3'b001: instr = {b12, half_i[8], half_i[10:9], half_i[6], half_i[7], half_i[2],
                                     half_i[11], half_i[5:3], b12, {8{b12}}, 5'd1, OPC_JAL};
                    3'b010: instr = {imm6_sx, 5'd0, F3_ADD, rd, OPC_OP_IMM};
                    3'b011: begin
                        if (rd == 5'd2) begin
                            instr = {{3{b12}}, half_i[4:3], half_i[5], half_i[2], half_i[6], 4'b0000,
                                     5'd2, F3_ADD, 5'd2, OPC_OP_IMM};
                        end else begin
                            instr = {{15{b12}}, half_i[6:2], rd, OPC_LUI};
                        end
                        illegal = ({b12, half_i[6:2]} == 6'd0);
                    end
                    3'b100: begin
                        case (half_i[11:10])
                            2'b00: begin
                                instr   = {F7_ZERO, half_i[6:2], rs1p, F3_SR, rs1p, OPC_OP_IMM};
                                illegal = b12;
                            end
                            2'b01: begin
                                instr   = {F7_ALT, half_i[6:2], rs1p, F3_SR, rs1p, OPC_OP_IMM};
                                illegal = b12;
                            end
                            2'b10: instr = {imm6_sx, rs1p, F3_AND, rs1p, OPC_OP_IMM};
                            default: begin
                                illegal = b12;
                                case (half_i[6:5])
                                    2'b00:   instr = {F7_ALT,  rdp, rs1p, F3_ADD, rs1p, OPC_OP};
                                    2'b01:   instr = {F7_ZERO, rdp, rs1p, F3_XOR, rs1p, OPC_OP};
                                    2'b10:   instr = {F7_ZERO, rdp, rs1p, F3_OR,  rs1p, OPC_OP};
                                    default: instr = {F7_ZERO, rdp, rs1p, F3_AND, rs1p, OPC_OP};
                                endcase
                            end
                        endcase
                    end
                    3'b101: instr = {b12, half_i[8], half_i[10:9], half_i[6], half_i[7], half_i[2],
                                     half_i[11], half_i[5:3], b12, {8{b12}}, 5'd0, OPC_JAL};
                    3'b110: instr = {b12, {3{b12}}, half_i[6:5], half_i[2], 5'd0, rs1p, F3_BEQ,
                                     half_i[11:10], half_i[4:3], b12, OPC_BRANCH};
                    default: instr = {b12, {3{b12}}, half_i[6:5], half_i[2], 5'd0, rs1p, F3_BNE,
                                      half_i[11:10], half_i[4:3], b12, OPC_BRANCH};
                endcase
            end
            2'b10: begin
                case (half_i[15:13])
                    3'b000: begin
                        instr   = {F7_ZERO, half_i[6:2], rd, F3_SLL, rd, OPC_OP_IMM};
                        illegal = b12;
                    end
                    3'b010: begin
                        instr   = {4'b0, half_i[3:2], b12, half_i[6:4], 2'b00, 5'd2, F3_W, rd, OPC_LOAD};
                        illegal = (rd == 5'd0);
                    end
                    3'b100: begin
                        if (!b12) begin
                            if (rs2 == 5'd0) begin
                                instr   = {12'h000, rd, F3_ADD, 5'd0, OPC_JALR};
                                illegal = (rd == 5'd0);
                            end else begin
                                instr = {F7_ZERO, rs2, 5'd0, F3_ADD, rd, OPC_OP};
                            end
                        end else if (rs2 == 5'd0) begin
                            instr = (rd == 5'd0) ? EBREAK_INSTR
                                                 : {12'h000, rd, F3_ADD, 5'd1, OPC_JALR};
                        end else begin
                            instr = {F7_ZERO, rs2, rd, F3_ADD, rd, OPC_OP};
                        end
                    end
                    3'b110: instr = {4'b0, half_i[8:7], b12, rs2, 5'd2, F3_W,
                                     half_i[11:9], 2'b00, OPC_STORE};
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b0;
        endcase
    end

`ifdef RVC_HINT_ILLEGAL_EN
    logic hint;

    // Flag HINT encodings (legal-but-no-effect forms) so they trap.
    always_comb begin
        hint = 1'b0;
        case ({half_i[15:13], half_i[1:0]})
            5'b000_01: hint = (rd == 5'd0) ? (imm6_sx != 12'd0) : (imm6_sx == 12'd0);
            5'b010_01: hint = (rd == 5'd0);
            5'b011_01: hint = (rd == 5'd0);
            5'b100_10: hint = (rs2 != 5'd0) && (rd == 5'd0);
            5'b000_10: hint = (rd == 5'd0) || ({b12, rs2} == 6'd0);
            default:   hint = 1'b0;
        endcase
    end

    assign expanded_c = '{illegal: illegal | hint, instr: instr};
`else
    assign expanded_c = '{illegal: illegal, instr: instr};
`endif

endmodule

// File: rtl/compress_decoder.sv
// Registered RV32C expander for the ID stage: pass-through for 32-bit words,
// expansion for RVC halfwords, with stall hold and synchronous reset to NOP.
// Defining RVC_HINT_ILLEGAL_EN makes hint encodings report as illegal.
module compress_decoder
    import compress_decoder_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    compress_decoder_if.slave       bus
);

    rvc_exp_t        expanded_c;
    logic            is_comp_c;
    logic [XLEN-1:0] instr_d, instr_q;
    logic            is_compressed_d, is_compressed_q;
    logic            illegal_d, illegal_q;

    rvc_expand_comb u_expand (
        .half_i     (bus.instr_i[HLEN-1:0]),
        .expanded_c (expanded_c)
    );

    assign is_comp_c = (bus.instr_i[1:0] != 2'b11);

    // Select pass-through / expansion / raw-halfword; hold while stalled.
    always_comb begin
        instr_d         = instr_q;
        is_compressed_d = is_compressed_q;
        illegal_d       = illegal_q;
        if (bus.enable) begin
            if (!is_comp_c) begin
                instr_d         = bus.instr_i;
                is_compressed_d = 1'b0;
                illegal_d       = 1'b0;
            end else if (expanded_c.illegal) begin
                instr_d         = XLEN'(bus.instr_i[HLEN-1:0]);
                is_compressed_d = 1'b1;
                illegal_d       = 1'b1;
            end else begin
                instr_d         = expanded_c.instr;
                is_compressed_d = 1'b1;
                illegal_d       = 1'b0;
            end
        end
    end

    // Output registers; reset has priority over enable.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            instr_q         <= NOP_INSTR;
            is_compressed_q <= 1'b0;
            illegal_q       <= 1'b0;
        end else begin
            instr_q         <= instr_d;
            is_compressed_q <= is_compressed_d;
            illegal_q       <= illegal_d;
        end
    end

    assign bus.instr_o         = instr_q;
    assign bus.is_compressed_o = is_compressed_q;
    assign bus.illegal_instr_o = illegal_q;

endmodule

// File: tb/tb_compress_decoder.sv
// Scoreboard bench for compress_decoder: directed vectors, full halfword sweep,
// and randomized stall/reset traffic against a field-level reference model.
module tb_compress_decoder;

    typedef struct packed {
        logic        c;
        logic        ill;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic resetn;
    compress_decoder_if bus_if ();

    compress_decoder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  held;
    int    total = 0;
    int    bad   = 0;

    // Bit field of the halfword as an integer.
    function automatic int fld(input logic [15:0] c, input int hi, input int lo);
        return int'((32'(c) >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
    endfunction

    function automatic int sext(input int v, input int bits);
        return (v ^ (1 << (bits - 1))) - (1 << (bits - 1));
    endfunction

    // RV32I instruction formats.
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
        logic [31:0] x;
        x = 32'(imm);
        return {x[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3, input int op);
        logic [31:0] x;
        x = 32'(imm);
        return {x[11:5], 5'(rs2), 5'(rs1), 3'(f3), x[4:0], 7'(op)};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] x;
        x = 32'(imm);
        return {x[12], x[10:5], 5'(rs2), 5'(rs1), 3'(f3), x[4:1], x[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] x;
        x = 32'(imm);
        return {x[20], x[10:1], x[11], x[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    // Reference expansion: returns {illegal, instr}.
    function automatic logic [32:0] ref_expand(input logic [15:0] c);
        int          q, f3, rd, rs2, rdp, rs1p, b12, imm, sub;
        logic        ill, hint;
        logic [31:0] r;
        int          alu_f3[4];
        alu_f3 = '{0, 4, 6, 7};
        q    = fld(c, 1, 0);
        f3   = fld(c, 15, 13);
        rd   = fld(c, 11, 7);
        rs2  = fld(c, 6, 2);
        rdp  = 8 + fld(c, 4, 2);
        rs1p = 8 + fld(c, 9, 7);
        b12  = fld(c, 12, 12);
        ill  = 1'b0;
        hint = 1'b0;
        r    = 32'h13;
        if (q == 0) begin
            if (f3 == 0) begin
                imm = (fld(c, 12, 11) << 4) | (fld(c, 10, 7) << 6) | (fld(c, 6, 6) << 2) | (fld(c, 5, 5) << 3);
                ill = (imm == 0);
                r   = enc_i(imm, 2, 0, rdp, 'h13);
            end else if (f3 == 2 || f3 == 6) begin
                imm = (fld(c, 12, 10) << 3) | (fld(c, 6, 6) << 2) | (fld(c, 5, 5) << 6);
                r   = (f3 == 2) ? enc_i(imm, rs1p, 2, rdp, 'h03) : enc_s(imm, rdp, rs1p, 2, 'h23);
            end else ill = 1'b1;
        end else if (q == 1) begin
            imm = sext((b12 << 5) | rs2, 6);
            case (f3)
                0: begin
                    r    = enc_i(imm, rd, 0, rd, 'h13);
                    hint = (rd == 0) ? (imm != 0) : (imm == 0);
                end
                1, 5: begin
                    imm = sext((b12 << 11) | (fld(c, 11, 11) << 4) | (fld(c, 10, 9) << 8) | (fld(c, 8, 8) << 10)
                               | (fld(c, 7, 7) << 6) | (fld(c, 6, 6) << 7) | (fld(c, 5, 3) << 1) | (fld(c, 2, 2) << 5), 12);
                    r = enc_j(imm, (f3 == 1) ? 1 : 0);
                end
                2: begin
                    r    = enc_i(imm, 0, 0, rd, 'h13);
                    hint = (rd == 0);
                end
                3: begin
                    if (rd == 2) begin
                        imm = sext((b12 << 9) | (fld(c, 4, 3) << 7) | (fld(c, 5, 5) << 6) | (fld(c, 2, 2) << 5)
                                   | (fld(c, 6, 6) << 4), 10);
                        r = enc_i(imm, 2, 0, 2, 'h13);
                    end else begin
                        r    = 32'(imm << 12) | 32'(rd << 7) | 32'h37;
                        hint = (rd == 0);
                    end
                    ill = (imm == 0);
                end
                4: begin
                    sub = fld(c, 11, 10);
                    if (sub <= 1) begin
                        ill = (b12 == 1);
                        r   = enc_i(((sub == 1) ? 'h20 : 0) * 32 + rs2, rs1p, 5, rs1p, 'h13);
                    end else if (sub == 2) begin
                        r = enc_i(imm, rs1p, 7, rs1p, 'h13);
                    end else begin
                        ill = (b12 == 1);
                        r   = enc_r((fld(c, 6, 5) == 0) ? 'h20 : 0, rdp, rs1p, alu_f3[fld(c, 6, 5)], rs1p, 'h33);
                    end
                end
                default: begin
                    imm = sext((b12 << 8) | (fld(c, 11, 10) << 3) | (fld(c, 6, 5) << 6) | (fld(c, 4, 3) << 1)
                               | (fld(c, 2, 2) << 5), 9);
                    r = enc_b(imm, 0, rs1p, (f3 == 6) ? 0 : 1);
                end
            endcase
        end else begin
            case (f3)
                0: begin
                    ill  = (b12 == 1);
                    r    = enc_i(rs2, rd, 1, rd, 'h13);
                    hint = (rd == 0) || (rs2 == 0);
                end
                2: begin
                    ill = (rd == 0);
                    imm = (b12 << 5) | (fld(c, 6, 4) << 2) | (fld(c, 3, 2) << 6);
                    r   = enc_i(imm, 2, 2, rd, 'h03);
                end
                6: begin
                    imm = (fld(c, 12, 9) << 2) | (fld(c, 8, 7) << 6);
                    r   = enc_s(imm, rs2, 2, 2, 'h23);
                end
                4: begin
                    if (b12 == 0) begin
                        if (rs2 == 0) begin
                            ill = (rd == 0);
                            r   = enc_i(0, rd, 0, 0, 'h67);
                        end else begin
                            r    = enc_r(0, rs2, 0, 0, rd, 'h33);
                            hint = (rd == 0);
                        end
                    end else if (rd == 0 && rs2 == 0) r = 32'h0010_0073;
                    else if (rs2 == 0) r = enc_i(0, rd, 0, 1, 'h67);
                    else begin
                        r    = enc_r(0, rs2, rd, 0, rd, 'h33);
                        hint = (rd == 0);
                    end
                end
                default: ill = 1'b1;
            endcase
        end
`ifdef RVC_HINT_ILLEGAL_EN
        ill = ill | hint;
`endif
        if (ill) r = {16'h0000, c};
        return {ill, r};
    endfunction

    function automatic exp_t top_model(input logic [31:0] w);
        logic [32:0] e;
        if (w[1:0] == 2'b11) return '{c: 1'b0, ill: 1'b0, instr: w};
        e = ref_expand(w[15:0]);
        return '{c: 1'b1, ill: e[32], instr: e[31:0]};
    endfunction

    // Drive one cycle of stimulus and queue what the outputs must show after the next edge.
    task automatic step(input logic rst_n, input logic en, input logic [31:0] w, input string nm);
        @(negedge clk);
        resetn         = rst_n;
        bus_if.enable  = en;
        bus_if.instr_i = w;
        if (!rst_n)  held = '{c: 1'b0, ill: 1'b0, instr: 32'h13};
        else if (en) held = top_model(w);
        exp_q.push_back(held);
        name_q.push_back(nm);
    endtask

    // Same as step, but with a hand-derived expectation.
    task automatic step_lit(input logic rst_n, input logic en, input logic [31:0] w, input exp_t e, input string nm);
        @(negedge clk);
        resetn         = rst_n;
        bus_if.enable  = en;
        bus_if.instr_i = w;
        held           = e;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expectation per clock edge once traffic starts.
    initial begin
        exp_t  e;
        exp_t  got;
        string n;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                n   = name_q.pop_front();
                got = '{c: bus_if.is_compressed_o, ill: bus_if.illegal_instr_o, instr: bus_if.instr_o};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got c=%0b ill=%0b instr=%h, want c=%0b ill=%0b instr=%h",
                             n, got.c, got.ill, got.instr, e.c, e.ill, e.instr);
                end
            end
        end
    end

    initial begin
        logic [31:0] w;
        resetn         = 1'b0;
        bus_if.enable  = 1'b0;
        bus_if.instr_i = 32'h0;

        step_lit(1'b0, 1'b0, 32'h0, '{c: 1'b0, ill: 1'b0, instr: 32'h0000_0013}, "reset");
        step_lit(1'b1, 1'b1, 32'hDEAD_0505, '{c: 1'b1, ill: 1'b0, instr: 32'h0015_0513}, "c.addi");
        step_lit(1'b1, 1'b1, 32'h0000_852E, '{c: 1'b1, ill: 1'b0, instr: 32'h00B0_0533}, "c.mv");
        step_lit(1'b1, 1'b1, 32'hFFFF_8082, '{c: 1'b1, ill: 1'b0, instr: 32'h0000_8067}, "c.jr");
        step_lit(1'b1, 1'b1, 32'h0000_0013, '{c: 1'b0, ill: 1'b0, instr: 32'h0000_0013}, "pass32");
        step_lit(1'b1, 1'b1, 32'h1234_0000, '{c: 1'b1, ill: 1'b1, instr: 32'h0000_0000}, "c0000");
        step_lit(1'b1, 1'b1, 32'h0000_9002, '{c: 1'b1, ill: 1'b0, instr: 32'h0010_0073}, "c.ebreak");
        step_lit(1'b1, 1'b1, 32'h0000_0505, '{c: 1'b1, ill: 1'b0, instr: 32'h0015_0513}, "load");
        step_lit(1'b1, 1'b0, 32'h0000_8082, '{c: 1'b1, ill: 1'b0, instr: 32'h0015_0513}, "stall");
        step_lit(1'b0, 1'b1, 32'h0000_8082, '{c: 1'b0, ill: 1'b0, instr: 32'h0000_0013}, "rst_en");
`ifdef RVC_HINT_ILLEGAL_EN
        step_lit(1'b1, 1'b1, 32'h0000_4001, '{c: 1'b1, ill: 1'b1, instr: 32'h0000_4001}, "c.li0");
`else
        step_lit(1'b1, 1'b1, 32'h0000_4001, '{c: 1'b1, ill: 1'b0, instr: 32'h0000_0013}, "c.li0");
`endif

        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 1'b1, {16'($urandom), 16'(i)}, "sweep");
        end

        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[1:0] = 2'($urandom_range(0, 2));
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), w, "rand");
        end

        for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
